// File: rtl/scanner_ctrl_p.sv
// Scanner power/buffer controller: sequences scan, idle, flush and standby modes
// from host strobes on a prescaled timebase and tracks buffer occupancy.
//
// state     | meaning
// LOW_POWER | quiescent, buffer contents retained
// ACTIVE    | scanning, one buffer unit added per tick
// STANDBY   | waiting for host, times out to LOW_POWER
// IDLE      | scan finished, waiting for transfer or append
// FLUSH     | draining buffer, one unit per tick
module scanner_ctrl_p #(
  parameter int PRESCALE      = 4,
  parameter int BUF_DEPTH     = 8,
  parameter int SCAN_TICKS    = 3,
  parameter int IDLE_TICKS    = 5,
  parameter int STANDBY_TICKS = 6,
  localparam int FW = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scan,
  input  logic          transfer,
  input  logic          go_standby,
  input  logic          abort,
  output logic [2:0]    state,
  output logic [FW-1:0] fill,
  output logic          buf_full,
  output logic          scan_done,
  output logic          flush_done,
  output logic          busy
);

  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TMAX = (SCAN_TICKS > IDLE_TICKS)
                        ? ((SCAN_TICKS > STANDBY_TICKS) ? SCAN_TICKS : STANDBY_TICKS)
                        : ((IDLE_TICKS > STANDBY_TICKS) ? IDLE_TICKS : STANDBY_TICKS);
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_LOW_POWER = 3'b000,
    S_ACTIVE    = 3'b001,
    S_STANDBY   = 3'b010,
    S_IDLE      = 3'b011,
    S_FLUSH     = 3'b100
  } state_t;

  state_t        state_q, state_n;
  logic [FW-1:0] fill_q, fill_n;
  logic [PW-1:0] presc_q;
  logic [TW-1:0] timer_q, timer_n;
  logic          sd_q, sd_n, fd_q, fd_n;
  logic          tick, full;

  assign tick = (presc_q == PW'(PRESCALE - 1));
  assign full = (fill_q == FW'(BUF_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOW_POWER;
      fill_q  <= '0;
      presc_q <= '0;
      timer_q <= '0;
      sd_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      fill_q  <= fill_n;
      presc_q <= tick ? '0 : presc_q + 1'b1;
      timer_q <= timer_n;
      sd_q    <= sd_n;
      fd_q    <= fd_n;
    end
  end

  always_comb begin
    state_n = state_q;
    fill_n  = fill_q;
    sd_n    = 1'b0;
    fd_n    = 1'b0;
    if (abort) begin
      state_n = S_LOW_POWER;
      fill_n  = '0;
    end else begin
      case (state_q)
        S_LOW_POWER: begin
          if (transfer && fill_q != '0) state_n = S_FLUSH;
          else if (scan && !full)       state_n = S_ACTIVE;
          else if (go_standby)          state_n = S_STANDBY;
        end
        S_ACTIVE: begin
          if (tick) begin
            if (!full) fill_n = fill_q + 1'b1;
            if (timer_q == TW'(SCAN_TICKS - 1)) begin
              state_n = S_IDLE;
              sd_n    = 1'b1;
            end
          end
        end
        S_IDLE: begin
          if (transfer)                                   state_n = S_FLUSH;
          else if (scan && !full)                         state_n = S_ACTIVE;
          else if (go_standby)                            state_n = S_STANDBY;
          else if (tick && timer_q == TW'(IDLE_TICKS - 1)) state_n = S_LOW_POWER;
        end
        S_FLUSH: begin
          if (tick) begin
            if (fill_q != '0) fill_n = fill_q - 1'b1;
            // last unit drained (or nothing to drain) ends the flush on this tick
            if (fill_q <= FW'(1)) begin
              state_n = S_LOW_POWER;
              fd_n    = 1'b1;
            end
          end
        end
        S_STANDBY: begin
          if (transfer && fill_q != '0)                      state_n = S_FLUSH;
          else if (scan && !full)                            state_n = S_ACTIVE;
          else if (tick && timer_q == TW'(STANDBY_TICKS - 1)) state_n = S_LOW_POWER;
        end
        default: state_n = S_LOW_POWER;
      endcase
    end
  end

  // timer restarts on any mode change; saturates so LOW_POWER/FLUSH never wrap it
  always_comb begin
    timer_n = timer_q;
    if (state_n != state_q)
      timer_n = '0;
    else if (tick && timer_q != TW'(TMAX))
      timer_n = timer_q + 1'b1;
  end

  assign state      = state_q;
  assign fill       = fill_q;
  assign buf_full   = full;
  assign scan_done  = sd_q;
  assign flush_done = fd_q;
  assign busy       = (state_q == S_ACTIVE) || (state_q == S_FLUSH);

endmodule

// File: tb/tb_scanner_ctrl_p.sv
// Scoreboard bench for scanner_ctrl_p: a mode-level reference model predicts
// every cycle's outputs; a separate monitor pops and compares after each edge.
module tb_scanner_ctrl_p;

  localparam int PRESCALE      = 4;
  localparam int BUF_DEPTH     = 8;
  localparam int SCAN_TICKS    = 3;
  localparam int IDLE_TICKS    = 5;
  localparam int STANDBY_TICKS = 6;
  localparam int FW = $clog2(BUF_DEPTH + 1);
  localparam int VW = 3 + FW + 4;

  localparam int M_LP = 0, M_ACT = 1, M_SBY = 2, M_IDLE = 3, M_FLUSH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scan = 1'b0, transfer = 1'b0, go_standby = 1'b0, abort = 1'b0;
  logic [2:0]    state;
  logic [FW-1:0] fill;
  logic          buf_full, scan_done, flush_done, busy;

  scanner_ctrl_p #(
    .PRESCALE(PRESCALE), .BUF_DEPTH(BUF_DEPTH), .SCAN_TICKS(SCAN_TICKS),
    .IDLE_TICKS(IDLE_TICKS), .STANDBY_TICKS(STANDBY_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .scan(scan), .transfer(transfer),
    .go_standby(go_standby), .abort(abort), .state(state), .fill(fill),
    .buf_full(buf_full), .scan_done(scan_done), .flush_done(flush_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;
  logic [VW-1:0] exp_q[$];

  // reference model: mode, occupancy, ticks seen in current mode, edges since reset
  int m_mode, m_fill, m_ticks, m_cyc;
  bit m_sd, m_fd;

  function automatic string fmt(input logic [VW-1:0] v);
    return $sformatf("state=%0d fill=%0d full=%0b sd=%0b fd=%0b busy=%0b",
                     v[VW-1 -: 3], v[FW+3:4], v[3], v[2], v[1], v[0]);
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {3'(m_mode), FW'(m_fill), (m_fill == BUF_DEPTH), m_sd, m_fd,
            (m_mode == M_ACT || m_mode == M_FLUSH)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {state, fill, buf_full, scan_done, flush_done, busy};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got %s want %s", name, $time, fmt(act), fmt(exp));
    end
  endtask

  task automatic model_reset();
    m_mode = M_LP; m_fill = 0; m_ticks = 0; m_cyc = 0; m_sd = 0; m_fd = 0;
  endtask

  task automatic model_step(input bit s, input bit t, input bit g, input bit a);
    bit tick, full;
    int nm, nf;
    tick = (m_cyc % PRESCALE) == (PRESCALE - 1);
    m_cyc++;
    full = (m_fill == BUF_DEPTH);
    nm = m_mode; nf = m_fill; m_sd = 0; m_fd = 0;
    if (a) begin
      nm = M_LP; nf = 0;
    end else if (m_mode == M_LP) begin
      if (t && m_fill > 0)  nm = M_FLUSH;
      else if (s && !full)  nm = M_ACT;
      else if (g)           nm = M_SBY;
    end else if (m_mode == M_ACT) begin
      if (tick) begin
        nf = (m_fill < BUF_DEPTH) ? m_fill + 1 : m_fill;
        if (m_ticks + 1 == SCAN_TICKS) begin nm = M_IDLE; m_sd = 1; end
      end
    end else if (m_mode == M_IDLE) begin
      if (t)                                      nm = M_FLUSH;
      else if (s && !full)                        nm = M_ACT;
      else if (g)                                 nm = M_SBY;
      else if (tick && m_ticks + 1 == IDLE_TICKS) nm = M_LP;
    end else if (m_mode == M_FLUSH) begin
      if (tick) begin
        if (m_fill > 0) nf = m_fill - 1;
        if (m_fill <= 1) begin nm = M_LP; m_fd = 1; end
      end
    end else begin
      if (t && m_fill > 0)                           nm = M_FLUSH;
      else if (s && !full)                           nm = M_ACT;
      else if (tick && m_ticks + 1 == STANDBY_TICKS) nm = M_LP;
    end
    if (nm != m_mode) m_ticks = 0;
    else if (tick)    m_ticks++;
    m_mode = nm;
    m_fill = nf;
  endtask

  task automatic cyc(input bit s, input bit t, input bit g, input bit a);
    @(negedge clk);
    rst = 1'b1; scan = s; transfer = t; go_standby = g; abort = a;
    model_step(s, t, g, a);
    exp_q.push_back(model_vec());
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask

  // reset asserted between edges; outputs must clear before any clock edge
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; scan = 0; transfer = 0; go_standby = 0; abort = 0;
    #1;
    check("async_reset", dut_vec(), '0);
    model_reset();
    exp_q.push_back('0);
  endtask

  initial begin : monitor
    logic [VW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", dut_vec(), e);
      end else if (started) begin
        total++; bad++;
        $display("FAIL underrun t=%0t got %s want queued expectation", $time, fmt(dut_vec()));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    #2 rst = 1'b0;
    #1 check("reset_defaults", dut_vec(), '0);
    model_reset();
    exp_q.push_back('0);
    started = 1'b1;

    cyc(1, 0, 0, 0); idle(14);                  // first scan -> IDLE fill 3
    cyc(1, 0, 0, 0); idle(14);                  // append -> fill 6
    cyc(1, 0, 0, 0); idle(14);                  // saturate at 8
    cyc(1, 0, 0, 0); idle(3);                   // scan while full ignored
    cyc(0, 1, 0, 0); idle(40);                  // flush all
    cyc(1, 0, 0, 0); idle(14);
    idle(25);                                   // idle timeout, fill retained
    cyc(0, 1, 0, 0); idle(20);                  // flush from LOW_POWER
    cyc(0, 1, 0, 0); idle(3);                   // transfer with fill 0 ignored
    cyc(1, 0, 1, 0); idle(14);                  // scan beats go_standby
    cyc(0, 0, 0, 1); idle(2);
    cyc(0, 0, 1, 0); idle(30);                  // standby timeout
    cyc(0, 0, 1, 0); idle(5);
    cyc(1, 0, 0, 0); idle(14);                  // scan from STANDBY
    cyc(0, 1, 0, 0); idle(40);
    cyc(1, 0, 0, 0); idle(6);                   // mid-ACTIVE
    do_reset();
    cyc(1, 0, 0, 0); idle(14);
    cyc(1, 0, 0, 0); idle(14);                  // fill 6
    cyc(0, 1, 0, 0); idle(4);                   // one tick -> fill 5
    cyc(0, 0, 0, 1); idle(3);                   // abort in FLUSH

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3)
        do_reset();
      else
        cyc($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end

    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
